// File: rtl/bp_lce_req_serializer.sv
// bp_lce_req_serializer
// Turns one LCE request (a header plus an optional cache-block payload) into a
// stream of network beats: first the header beat, then only as many data beats
// as the bedrock size code needs.
// The header, data and beat count are captured when the message is accepted.
// The outgoing beats therefore never depend on the live message inputs.
module bp_lce_req_serializer #(
  parameter int header_width_p = 128,
  parameter int data_width_p   = 512,
  parameter int beat_width_p   = 128
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [header_width_p-1:0] msg_header_i,
  input  logic [data_width_p-1:0]   msg_data_i,
  input  logic [2:0]                msg_size_i,
  input  logic                      msg_has_data_i,
  input  logic                      msg_v_i,
  output logic                      msg_ready_o,
  output logic [beat_width_p-1:0]   beat_o,
  output logic                      beat_last_o,
  output logic                      beat_v_o,
  input  logic                      beat_ready_i
);

  localparam int max_beats_lp = data_width_p / beat_width_p;
  localparam int idx_width_lp = (max_beats_lp > 1) ? $clog2(max_beats_lp) : 1;
  localparam int cnt_width_lp = $clog2(max_beats_lp + 1);
  localparam logic [31:0] beat_width_lp = beat_width_p;
  localparam logic [31:0] max_beats_u_lp = max_beats_lp;

  localparam logic [1:0] e_ready  = 2'd0;
  localparam logic [1:0] e_header = 2'd1;
  localparam logic [1:0] e_data   = 2'd2;

  // The parameter combinations below cannot produce a legal beat stream.
  if ((header_width_p > beat_width_p) || (beat_width_p < 64)
      || ((data_width_p % beat_width_p) != 0)) begin : g_bad_params
    $error("bp_lce_req_serializer: illegal header/data/beat width combination");
  end

  logic [1:0]                r_state;
  logic [header_width_p-1:0] r_header;
  logic [data_width_p-1:0]   r_data;
  logic [cnt_width_lp-1:0]   r_cnt;
  logic [idx_width_lp-1:0]   r_idx;

  logic [31:0]               w_bits;
  logic [31:0]               w_raw_beats;
  logic [cnt_width_lp-1:0]   w_cnt;
  logic [beat_width_p-1:0]   w_header_beat;
  logic                      w_data_last;
  logic                      w_accept;

  // Number of data beats the incoming message needs: at least one, at most a whole block.
  always_comb begin
    w_bits      = 32'd8 << msg_size_i;
    w_raw_beats = w_bits / beat_width_lp;
    w_cnt       = '0;
    if (msg_has_data_i) begin
      if (w_raw_beats == 32'd0) begin
        w_cnt = cnt_width_lp'(1);
      end else if (w_raw_beats > max_beats_u_lp) begin
        w_cnt = cnt_width_lp'(max_beats_lp);
      end else begin
        w_cnt = cnt_width_lp'(w_raw_beats);
      end
    end
  end

  // Header zero-extended to a full beat, and end-of-data detection.
  always_comb begin
    w_header_beat                     = '0;
    w_header_beat[header_width_p-1:0] = r_header;
    w_data_last = (32'(r_idx) == (32'(r_cnt) - 32'd1));
  end

  // Output steering. Ready is gated by reset so that it drops immediately on reset assertion.
  always_comb begin
    msg_ready_o = (r_state == e_ready) && reset_n_i;
    w_accept    = msg_v_i && msg_ready_o;
    beat_v_o    = (r_state == e_header) || (r_state == e_data);
    beat_o      = '0;
    beat_last_o = 1'b0;
    if (r_state == e_header) begin
      beat_o      = w_header_beat;
      beat_last_o = (r_cnt == '0);
    end else if (r_state == e_data) begin
      beat_o      = r_data[32'(r_idx) * beat_width_p +: beat_width_p];
      beat_last_o = w_data_last;
    end
  end

  // Message capture and beat sequencing. Reset abandons any message that is in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= e_ready;
      r_header <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        e_ready: begin
          if (w_accept) begin
            r_header <= msg_header_i;
            r_data   <= msg_data_i;
            r_cnt    <= w_cnt;
            r_idx    <= '0;
            r_state  <= e_header;
          end
        end
        e_header: begin
          if (beat_ready_i) begin
            r_idx   <= '0;
            r_state <= (r_cnt == '0) ? e_ready : e_data;
          end
        end
        e_data: begin
          if (beat_ready_i) begin
            if (w_data_last) begin
              r_idx   <= '0;
              r_state <= e_ready;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= e_ready;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_lce_req_serializer.sv
// tb_bp_lce_req_serializer
// Directed test of the LCE request serializer using the default widths
// (128-bit header, 512-bit block, 128-bit beats).
module tb_bp_lce_req_serializer;

  logic         clk_i;
  logic         reset_n_i;
  logic [127:0] msg_header_i;
  logic [511:0] msg_data_i;
  logic [2:0]   msg_size_i;
  logic         msg_has_data_i;
  logic         msg_v_i;
  logic         msg_ready_o;
  logic [127:0] beat_o;
  logic         beat_last_o;
  logic         beat_v_o;
  logic         beat_ready_i;

  int totalCount;
  int badCount;

  logic [511:0] dataVec;
  logic [127:0] expBeats [5];
  int           beatIdx;

  bp_lce_req_serializer dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .msg_header_i   (msg_header_i),
    .msg_data_i     (msg_data_i),
    .msg_size_i     (msg_size_i),
    .msg_has_data_i (msg_has_data_i),
    .msg_v_i        (msg_v_i),
    .msg_ready_o    (msg_ready_o),
    .beat_o         (beat_o),
    .beat_last_o    (beat_last_o),
    .beat_v_o       (beat_v_o),
    .beat_ready_i   (beat_ready_i)
  );

  // 10 ns free-running clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One comparison point: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    totalCount++;
    assert (obs === exp) else begin
      badCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a message on the input side.
  task automatic applyStimulus(input logic v, input logic hasData, input logic [2:0] size,
                               input logic [127:0] header, input logic [511:0] data,
                               input logic beatReady);
    msg_v_i        = v;
    msg_has_data_i = hasData;
    msg_size_i     = size;
    msg_header_i   = header;
    msg_data_i     = data;
    beat_ready_i   = beatReady;
  endtask

  // Withdraw the message and scramble the inputs, so that any beat taken from the live inputs shows up.
  task automatic dropMessage(input logic beatReady);
    applyStimulus(1'b0, 1'b1, 3'd6, 128'hDEAD_BEEF, {16{32'hBAD0_BAD0}}, beatReady);
  endtask

  initial begin
    totalCount = 0;
    badCount   = 0;
    reset_n_i  = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, '0, '0, 1'b1);

    // Reset values.
    #3;
    checkOutput("rst_ready", 128'(msg_ready_o), 128'd0);
    checkOutput("rst_v", 128'(beat_v_o), 128'd0);
    checkOutput("rst_last", 128'(beat_last_o), 128'd0);
    #4 reset_n_i = 1'b1;
    tick();
    checkOutput("post_rst_ready", 128'(msg_ready_o), 128'd1);
    checkOutput("post_rst_v", 128'(beat_v_o), 128'd0);

    // A read request is sent as a single header beat.
    applyStimulus(1'b1, 1'b0, 3'd3, 128'hABCD, '0, 1'b1);
    tick();
    dropMessage(1'b1);
    checkOutput("rd_v", 128'(beat_v_o), 128'd1);
    checkOutput("rd_beat", beat_o, 128'hABCD);
    checkOutput("rd_last", 128'(beat_last_o), 128'd1);
    checkOutput("rd_busy", 128'(msg_ready_o), 128'd0);
    tick();
    checkOutput("rd_done_ready", 128'(msg_ready_o), 128'd1);
    checkOutput("rd_done_v", 128'(beat_v_o), 128'd0);

    // An 8-byte uncached store needs one data beat.
    dataVec = '0;
    dataVec[63:0] = 64'h1122334455667788;
    applyStimulus(1'b1, 1'b1, 3'd3, 128'h5A5A, dataVec, 1'b1);
    tick();
    dropMessage(1'b1);
    checkOutput("uc8_hdr", beat_o, 128'h5A5A);
    checkOutput("uc8_hdr_last", 128'(beat_last_o), 128'd0);
    tick();
    checkOutput("uc8_data_v", 128'(beat_v_o), 128'd1);
    checkOutput("uc8_data", beat_o, 128'h1122334455667788);
    checkOutput("uc8_data_last", 128'(beat_last_o), 128'd1);
    tick();
    checkOutput("uc8_done_ready", 128'(msg_ready_o), 128'd1);
    checkOutput("uc8_done_v", 128'(beat_v_o), 128'd0);

    // A 64-byte store with data beat k = k+1 produces a header and four data beats.
    for (int k = 0; k < 4; k++) dataVec[k*128 +: 128] = 128'(k + 1);
    applyStimulus(1'b1, 1'b1, 3'd6, 128'h64, dataVec, 1'b1);
    tick();
    dropMessage(1'b1);
    checkOutput("b64_hdr", beat_o, 128'h64);
    checkOutput("b64_hdr_last", 128'(beat_last_o), 128'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("b64_data", beat_o, 128'(k + 1));
      checkOutput("b64_last", 128'(beat_last_o), 128'(k == 3));
    end
    tick();
    checkOutput("b64_done_ready", 128'(msg_ready_o), 128'd1);

    // The same message with beat_ready toggling every cycle takes ten cycles to drain.
    expBeats[0] = 128'h64;
    for (int k = 1; k < 5; k++) expBeats[k] = 128'(k);
    applyStimulus(1'b1, 1'b1, 3'd6, 128'h64, dataVec, 1'b0);
    tick();
    dropMessage(1'b0);
    beatIdx = 0;
    for (int c = 0; c < 10; c++) begin
      beat_ready_i = (c % 2) == 1;
      #1;
      checkOutput("stall_v", 128'(beat_v_o), 128'd1);
      checkOutput("stall_beat", beat_o, expBeats[beatIdx]);
      checkOutput("stall_last", 128'(beat_last_o), 128'(beatIdx == 4));
      checkOutput("stall_ready", 128'(msg_ready_o), 128'd0);
      tick();
      if (c % 2 == 1) beatIdx++;
    end
    checkOutput("stall_done_ready", 128'(msg_ready_o), 128'd1);
    checkOutput("stall_done_v", 128'(beat_v_o), 128'd0);
    beat_ready_i = 1'b1;

    // A 128-byte size code is clamped to the four beats of one block.
    for (int k = 0; k < 4; k++) dataVec[k*128 +: 128] = 128'(k + 16);
    applyStimulus(1'b1, 1'b1, 3'd7, 128'h77, dataVec, 1'b1);
    tick();
    dropMessage(1'b1);
    checkOutput("b128_hdr", beat_o, 128'h77);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("b128_data", beat_o, 128'(k + 16));
      checkOutput("b128_last", 128'(beat_last_o), 128'(k == 3));
    end
    tick();
    checkOutput("b128_done_ready", 128'(msg_ready_o), 128'd1);
    checkOutput("b128_done_v", 128'(beat_v_o), 128'd0);

    // Reset asserted during data beat 2 throws the message away at once.
    for (int k = 0; k < 4; k++) dataVec[k*128 +: 128] = 128'(k + 1);
    applyStimulus(1'b1, 1'b1, 3'd6, 128'h99, dataVec, 1'b1);
    tick();
    dropMessage(1'b1);
    tick();
    tick();
    tick();
    checkOutput("mid_beat2", beat_o, 128'd3);
    #2 reset_n_i = 1'b0;
    #1;
    checkOutput("mid_rst_v", 128'(beat_v_o), 128'd0);
    checkOutput("mid_rst_last", 128'(beat_last_o), 128'd0);
    checkOutput("mid_rst_ready", 128'(msg_ready_o), 128'd0);
    #2 reset_n_i = 1'b1;
    tick();
    checkOutput("mid_post_ready", 128'(msg_ready_o), 128'd1);
    for (int c = 0; c < 3; c++) begin
      checkOutput("mid_no_stale", 128'(beat_v_o), 128'd0);
      tick();
    end

    // The block still works normally after the aborted message.
    applyStimulus(1'b1, 1'b0, 3'd0, 128'h55, '0, 1'b1);
    tick();
    dropMessage(1'b1);
    checkOutput("after_beat", beat_o, 128'h55);
    checkOutput("after_last", 128'(beat_last_o), 128'd1);
    tick();
    checkOutput("after_ready", 128'(msg_ready_o), 128'd1);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
